sha256_padder: RTL
==================

# sha256_padder

Upstream front-end of the SHA-256/224 datapath. It accepts the raw message as a stream of 32-bit big-endian words and builds 512-bit blocks from them. It applies FIPS 180-4 padding: a 0x80 marker, zero fill, and the 64-bit bit-length. Completed blocks are presented to the hashing core's block input through a valid/ready handshake, with a flag marking the final block of the message.

## Interface
Parameters:
- BlockWidth, 512, output block width; only 512 is supported.
- LenWidth, 64, width of the message bit-length field and counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock, synchronous, active-high.
- clear_i  in  1  synchronous abort; discards the current message.
- data_i  in  32  message word; first byte in [31:24].
- bytes_i  in  3  valid bytes in data_i, 0..4, left-aligned; values below 4 are legal only with last_i.
- last_i  in  1  data_i is the final word of the message.
- valid_i  in  1  input word valid.
- ready_o  out  1  padder can accept a word.
- block_o  out  512  block; word 0 is in [511:480].
- block_valid_o  out  1  block_o holds a complete block.
- block_last_o  out  1  this is the final (padded) block of the message.
- block_ready_i  in  1  core consumes the block.
- msg_len_o  out  64  running message length in bits.

## Operation
States: FILL, EMIT, EXTRA.

FILL:
- ready_o=1.
- A word is accepted on valid_i & ready_o and written to word index widx (4-bit).
- Bytes beyond bytes_i are zeroed on write.
- msg_len += 8*bytes_i; the counter wraps modulo 2^64.
- Non-last word with widx=15 → EMIT, block_last_o=0, widx←0.
- Last word: the 0x80 marker byte position is p = 4*widx + bytes_i.
  - If p<64, write 0x80 at byte p and zero every later byte of the buffer.
  - If p≤55, write msg_len (post-increment) big-endian into words 14–15, set block_last_o=1, go to EMIT.
  - Otherwise go to EMIT with block_last_o=0 and a pending-extra flag set. The flag records whether p==64, meaning the marker has not yet been written.

EMIT:
- block_valid_o=1, ready_o=0.
- On block_ready_i:
  - pending-extra flag set → EXTRA.
  - Else if block_last_o=1 → clear msg_len and the buffer, go to FILL.
  - Else → FILL.

EXTRA:
- Takes one cycle.
- Buffer ← all zeros; word 0 = 0x80000000 if p==64; words 14–15 = msg_len.
- block_last_o=1, clear pending-extra flag, go to EMIT.

Boundary rules:
- clear_i (any state): buffer, widx, msg_len and flags are cleared; state → FILL; block_valid_o drops next cycle; the word presented in that cycle is not accepted. clear_i takes priority over a simultaneous valid_i or block_ready_i.
- rst_i has the same effect as clear_i and takes priority over it.
- An empty message (last_i with bytes_i=0 at widx=0) is legal and yields one block.
- bytes_i=0 without last_i, or bytes_i>4: the word is accepted, no length is added, and no data is written. This is a verification error case.

## Timing
- Reset values: ready_o=1, block_valid_o=0, block_last_o=0, block_o=0, msg_len_o=0, state=FILL.
- block_valid_o rises the cycle after the accepting edge of the 16th word or the last word.
- Extra block: block_valid_o falls for exactly one cycle (EXTRA), then rises with the length block.
- block_o and block_last_o are stable while block_valid_o=1 && !block_ready_i.
- The first word of the next message can be accepted the cycle after the block handshake.
- Throughput: 16 input cycles plus 1 handshake cycle per block when block_ready_i is held high.

## Structure
- Shared package sha256_pkg holds:
  - the padder_state_e enum (FILL, EMIT, EXTRA);
  - constants PadMarker=8'h80, BlockWords=16, LenWidth;
  - a byte-mask function mask(bytes) → 32-bit left-aligned mask.
- No sub-module is needed: one FSM, a 16×32 buffer register, a 4-bit word counter and a 64-bit length counter.

## Test plan
- "abc": data 0x61626300, bytes=3, last → one block. Word0 0x61626380, words1–14 0, word15 0x00000018, last=1.
- Empty message: bytes=0, last → word0 0x80000000, all other words 0, last=1.
- 56 bytes (14 full words, last on the 14th) → two blocks:
  - Block 1: word14 0x80000000, word15 0, last=0.
  - Block 2: words 0–14 zero, word15 0x000001C0, last=1.
- 64 bytes (16 full words) → two blocks:
  - Block 1: raw data, last=0.
  - Block 2: word0 0x80000000, word15 0x00000200, last=1.
- Backpressure: hold block_ready_i low 5 cycles → block_o stable, ready_o=0, no words accepted; handshake on cycle 6, then ready_o=1.
- clear_i after 7 words, then "abc" → the output matches the standalone "abc" case; msg_len_o=24. Repeat with rst_i asserted during EMIT → block_valid_o=0 on the next cycle.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256/224 front-end: padder states, padding
// constants and the byte-lane mask helper.
package sha256_pkg;

  typedef enum logic [1:0] {
    FILL,
    EMIT,
    EXTRA
  } padder_state_e;

  localparam logic [7:0] PadMarker  = 8'h80;
  localparam int         BlockWords = 16;
  localparam int         LenWidth   = 64;

  // Left-aligned mask keeping the first 'bytes' bytes of a big-endian word.
  function automatic logic [31:0] mask(input logic [2:0] bytes);
    logic [31:0] m;
    case (bytes)
      3'd0:    m = 32'h0000_0000;
      3'd1:    m = 32'hFF00_0000;
      3'd2:    m = 32'hFFFF_0000;
      3'd3:    m = 32'hFFFF_FF00;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sha256_padder.sv
// Message padder for the SHA-256/224 core: packs 32-bit big-endian words into
// 512-bit blocks, appends the 0x80 marker, zero fill and the 64-bit bit length,
// and hands blocks to the core over a valid/ready handshake.
module sha256_padder #(
  parameter int BlockWidth = 512,
  parameter int LenWidth   = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic [31:0]           data_i,
  input  logic [2:0]            bytes_i,
  input  logic                  last_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [BlockWidth-1:0] block_o,
  output logic                  block_valid_o,
  output logic                  block_last_o,
  input  logic                  block_ready_i,
  output logic [LenWidth-1:0]   msg_len_o
);

  import sha256_pkg::*;

  padder_state_e       state_q, state_d;
  logic [31:0]         buf_q [BlockWords];
  logic [31:0]         buf_d [BlockWords];
  logic [3:0]          widx_q, widx_d;
  logic [LenWidth-1:0] msg_len_q, msg_len_d;
  logic                last_q, last_d;
  logic                pend_q, pend_d;
  logic                marker_q, marker_d;

  logic [LenWidth-1:0] msg_len_inc;
  logic [63:0]         fill_len;
  logic [63:0]         extra_len;
  logic [6:0]          mark_pos;
  logic [6:0]          byte_pos;
  logic                word_ok;

  assign ready_o       = (state_q == FILL);
  assign block_valid_o = (state_q == EMIT);
  assign block_last_o  = last_q;
  assign msg_len_o     = msg_len_q;

  // Flatten the word buffer onto the block port, word 0 in the top bits.
  always_comb begin
    block_o = '0;
    for (int w = 0; w < BlockWords; w++) begin
      block_o[BlockWidth-1-32*w -: 32] = buf_q[w];
    end
  end

  // Next-state logic: word capture and padding in FILL, handshake in EMIT,
  // and construction of the separate length-only block in EXTRA.
  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    widx_d    = widx_q;
    msg_len_d = msg_len_q;
    last_d    = last_q;
    pend_d    = pend_q;
    marker_d  = marker_q;
    byte_pos  = '0;

    // Words with no byte count (unless they close the message) or an
    // impossible count are swallowed without touching buffer or length.
    word_ok     = (bytes_i <= 3'd4) && ((bytes_i != 3'd0) || last_i);
    msg_len_inc = msg_len_q + LenWidth'({bytes_i, 3'b000});
    fill_len    = 64'(msg_len_inc);
    extra_len   = 64'(msg_len_q);
    mark_pos    = {1'b0, widx_q, 2'b00} + {4'b0000, bytes_i};

    case (state_q)
      FILL: begin
        if (valid_i && word_ok) begin
          msg_len_d     = msg_len_inc;
          buf_d[widx_q] = data_i & mask(bytes_i);
          if (!last_i) begin
            widx_d = widx_q + 4'd1;
            if (widx_q == 4'd15) begin
              state_d = EMIT;
              last_d  = 1'b0;
            end
          end else begin
            widx_d  = '0;
            state_d = EMIT;
            // Marker lands right after the final data byte; everything
            // behind it is stale data from an earlier block and is wiped.
            for (int w = 0; w < BlockWords; w++) begin
              for (int l = 0; l < 4; l++) begin
                byte_pos = 7'(4*w + l);
                if (byte_pos == mark_pos) begin
                  buf_d[w][31-8*l -: 8] = PadMarker;
                end else if (byte_pos > mark_pos) begin
                  buf_d[w][31-8*l -: 8] = 8'h00;
                end
              end
            end
            if (mark_pos <= 7'd55) begin
              buf_d[14] = fill_len[63:32];
              buf_d[15] = fill_len[31:0];
              last_d    = 1'b1;
              pend_d    = 1'b0;
            end else begin
              // Length does not fit; a second block follows, and when the
              // data filled the block exactly the marker goes there too.
              last_d   = 1'b0;
              pend_d   = 1'b1;
              marker_d = (mark_pos == 7'd64);
            end
          end
        end
      end

      EMIT: begin
        if (block_ready_i) begin
          if (pend_q) begin
            state_d = EXTRA;
          end else begin
            state_d = FILL;
            if (last_q) begin
              msg_len_d = '0;
              for (int w = 0; w < BlockWords; w++) begin
                buf_d[w] = '0;
              end
            end
            last_d = 1'b0;
          end
        end
      end

      EXTRA: begin
        for (int w = 0; w < BlockWords; w++) begin
          buf_d[w] = '0;
        end
        if (marker_q) begin
          buf_d[0] = {PadMarker, 24'h000000};
        end
        buf_d[14] = extra_len[63:32];
        buf_d[15] = extra_len[31:0];
        last_d    = 1'b1;
        pend_d    = 1'b0;
        marker_d  = 1'b0;
        state_d   = EMIT;
      end

      default: begin
        state_d = FILL;
      end
    endcase

    // Abort wins over any word or handshake in the same cycle.
    if (clear_i) begin
      state_d   = FILL;
      widx_d    = '0;
      msg_len_d = '0;
      last_d    = 1'b0;
      pend_d    = 1'b0;
      marker_d  = 1'b0;
      for (int w = 0; w < BlockWords; w++) begin
        buf_d[w] = '0;
      end
    end
  end

  // State, buffer and counters register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= FILL;
      buf_q     <= '{default: '0};
      widx_q    <= '0;
      msg_len_q <= '0;
      last_q    <= 1'b0;
      pend_q    <= 1'b0;
      marker_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      widx_q    <= widx_d;
      msg_len_q <= msg_len_d;
      last_q    <= last_d;
      pend_q    <= pend_d;
      marker_q  <= marker_d;
    end
  end

endmodule
